alu_iter: RTL and testbench

- Parametrised, registered successor to the datapath ALU.
- Single-cycle logic, arithmetic and shift ops return a result one clock after issue.
- Iterative unsigned multiply and divide take WIDTH cycles and write MIPS-style HI/LO registers.
- Sits in the EX stage; the control path stalls on `busy` and consumes the result on `done`.

---
 rtl/alu_iter.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_iter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: registered EX-stage ALU with single-cycle logic/arith/shift ops
// and iterative unsigned multiply/divide that write MIPS-style HI/LO.
//
// Handshake: start/Aluctl/shamt/input1/input2 are sampled on a rising edge
// only while busy=0; a start seen while busy=1 is dropped with no capture.
// done is a one-cycle pulse marking the cycle in which Aluout/zflag hold a
// freshly written result; a new start may be presented in that same cycle.
module alu_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         Aluctl,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   input1,
    input  logic [WIDTH-1:0]   input2,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   Aluout,
    output logic               zflag,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SLL   = 4'd3;
    localparam logic [3:0] OP_SRL   = 4'd4;
    localparam logic [3:0] OP_SRA   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SLTU  = 4'd8;
    localparam logic [3:0] OP_XOR   = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_NOR   = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;
    localparam logic [3:0] OP_ORI   = 4'd15;

    // Low 16 bits of B form the ORI immediate; narrower datapaths use all bits.
    localparam logic [WIDTH-1:0]   IMM_MASK  = WIDTH'(32'h0000_FFFF);
    localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   b_q, b_d;           // multiplicand or divisor
    logic [WIDTH-1:0]   work_hi_q, work_hi_d; // product high / partial remainder
    logic [WIDTH-1:0]   work_lo_q, work_lo_d; // multiplier / dividend->quotient
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   aluout_q, aluout_d;
    logic               zflag_q, zflag_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   alu_res;
    logic               is_iter_op;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nxt;
    logic [WIDTH-1:0]   mul_lo_nxt;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_hi_nxt;
    logic [WIDTH-1:0]   div_lo_nxt;

    assign is_iter_op = (Aluctl == OP_MULTU) || (Aluctl == OP_DIVU);

    // Single-cycle result, computed straight from the issue-time inputs.
    always_comb begin
        alu_res = '0;
        case (Aluctl)
            OP_AND:  alu_res = input1 & input2;
            OP_OR:   alu_res = input1 | input2;
            OP_ADD:  alu_res = input1 + input2;
            OP_SLL:  alu_res = input2 << shamt;
            OP_SRL:  alu_res = input2 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(input2) >>> shamt);
            OP_SUB:  alu_res = input1 - input2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
            OP_XOR:  alu_res = input1 ^ input2;
            OP_NOR:  alu_res = ~(input1 | input2);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_ORI:  alu_res = input1 | (input2 & IMM_MASK);
            default: alu_res = '0;
        endcase
    end

    // One iteration step for each iterative op: shift-add multiply and
    // restoring shift-subtract divide. A zero divisor always "subtracts",
    // which naturally yields quotient all-ones and remainder = dividend.
    always_comb begin
        mul_sum    = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], work_lo_q[WIDTH-1:1]};

        div_shift  = {work_hi_q, work_lo_q[WIDTH-1]};
        div_ge     = (div_shift >= {1'b0, b_q});
        // When subtracting, the true difference is below b_q, so WIDTH bits suffice.
        div_hi_nxt = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
        div_lo_nxt = {work_lo_q[WIDTH-2:0], div_ge};
    end

    // Next-state and next-output logic for the IDLE/RUN/FIN sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        b_d       = b_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aluout_d  = aluout_q;
        zflag_d   = zflag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_iter_op) begin
                        state_d   = S_RUN;
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        is_div_d  = (Aluctl == OP_DIVU);
                        work_hi_d = '0;
                        if (Aluctl == OP_DIVU) begin
                            b_d       = input2;
                            work_lo_d = input1;
                        end else begin
                            b_d       = input1;
                            work_lo_d = input2;
                        end
                    end else begin
                        aluout_d = alu_res;
                        zflag_d  = (alu_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    work_hi_d = div_hi_nxt;
                    work_lo_d = div_lo_nxt;
                end else begin
                    work_hi_d = mul_hi_nxt;
                    work_lo_d = mul_lo_nxt;
                end
                cnt_d = cnt_q + SHAMT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                hi_d     = work_hi_q;
                lo_d     = work_lo_q;
                aluout_d = work_lo_q;
                zflag_d  = (work_lo_q == '0);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; synchronous reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            b_q       <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aluout_q  <= '0;
            zflag_q   <= 1'b1;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            b_q       <= b_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aluout_q  <= aluout_d;
            zflag_q   <= zflag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Aluout = aluout_q;
    assign zflag  = zflag_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed bench for alu_iter at WIDTH=32 with hand-computed
// expected values checked by immediate assertions.
module tb_alu_iter;

    localparam int W = 32;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SLL   = 4'd3;
    localparam logic [3:0] OP_SRL   = 4'd4;
    localparam logic [3:0] OP_SRA   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SLTU  = 4'd8;
    localparam logic [3:0] OP_XOR   = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_NOR   = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;
    localparam logic [3:0] OP_ORI   = 4'd15;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    Aluctl;
    logic [4:0]    shamt;
    logic [W-1:0]  input1;
    logic [W-1:0]  input2;
    logic          busy;
    logic          done;
    logic [W-1:0]  Aluout;
    logic          zflag;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int tests = 0;
    int fails = 0;

    alu_iter #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Aluctl (Aluctl),
        .shamt  (shamt),
        .input1 (input1),
        .input2 (input2),
        .busy   (busy),
        .done   (done),
        .Aluout (Aluout),
        .zflag  (zflag),
        .hi     (hi),
        .lo     (lo)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [W-1:0] b2w(input logic b);
        return {{(W-1){1'b0}}, b};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one single-cycle op; result and done must appear one edge later.
    task automatic single(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] sh, input logic [W-1:0] exp);
        start  = 1'b1;
        Aluctl = op;
        input1 = a;
        input2 = b;
        shamt  = sh;
        tick();
        start = 1'b0;
        chk({tag, " done"}, b2w(done), b2w(1'b1));
        chk({tag, " out"}, Aluout, exp);
        chk({tag, " zflag"}, b2w(zflag), b2w(exp == '0));
    endtask

    // Issue a MULTU/DIVU, scramble the inputs, optionally poke an ADD start
    // mid-run, then check busy length, the single done pulse and HI/LO.
    task automatic iter(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input bit inject);
        int busy_cnt;
        int done_seen;
        busy_cnt  = 0;
        done_seen = 0;
        start  = 1'b1;
        Aluctl = op;
        input1 = a;
        input2 = b;
        tick();
        start  = 1'b0;
        input1 = ~a;
        input2 = b ^ 32'h5A5A_A5A5;
        while (busy === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            if (done === 1'b1) done_seen++;
            if (inject && busy_cnt == 10) begin
                start  = 1'b1;
                Aluctl = OP_ADD;
                input1 = 32'h0000_0001;
                input2 = 32'h0000_0002;
            end
            tick();
            start = 1'b0;
        end
        chk({tag, " busy cycles"}, W'(busy_cnt), W'(33));
        chk({tag, " done during busy"}, W'(done_seen), '0);
        chk({tag, " done"}, b2w(done), b2w(1'b1));
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        chk({tag, " Aluout"}, Aluout, exp_lo);
        chk({tag, " zflag"}, b2w(zflag), b2w(exp_lo == '0));
        tick();
        chk({tag, " done one-shot"}, b2w(done), b2w(1'b0));
    endtask

    initial begin
        int late_done;
        reset  = 1'b1;
        start  = 1'b0;
        Aluctl = '0;
        shamt  = '0;
        input1 = '0;
        input2 = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();

        chk("reset Aluout", Aluout, '0);
        chk("reset zflag", b2w(zflag), b2w(1'b1));
        chk("reset busy", b2w(busy), b2w(1'b0));
        chk("reset done", b2w(done), b2w(1'b0));
        chk("reset hi", hi, '0);
        chk("reset lo", lo, '0);

        // Back-to-back single-cycle ops (each start lands in the previous done cycle).
        single("add wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000);
        single("slt", OP_SLT, 32'hFFFF_FFFE, 32'h0000_0001, 5'd0, 32'h0000_0001);
        single("sltu", OP_SLTU, 32'hFFFF_FFFE, 32'h0000_0001, 5'd0, 32'h0000_0000);
        single("sra", OP_SRA, 32'h0000_0000, 32'h8000_0000, 5'd4, 32'hF800_0000);
        tick();
        chk("sra done one-shot", b2w(done), b2w(1'b0));
        chk("sra Aluout held", Aluout, 32'hF800_0000);

        single("and", OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000);
        single("or", OP_OR, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_FFF0);
        single("xor", OP_XOR, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_0FF0);
        single("nor", OP_NOR, 32'h0000_0000, 32'h0000_0000, 5'd0, 32'hFFFF_FFFF);
        single("sub", OP_SUB, 32'h0000_0005, 32'h0000_0007, 5'd0, 32'hFFFF_FFFE);
        single("sll", OP_SLL, 32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000);
        single("srl", OP_SRL, 32'h0000_0000, 32'h8000_0000, 5'd4, 32'h0800_0000);
        tick();
        chk("singles leave hi", hi, '0);
        chk("singles leave lo", lo, '0);

        // Iterative ops.
        iter("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        single("mfhi", OP_MFHI, 32'h0000_0000, 32'h0000_0000, 5'd0, 32'hFFFF_FFFE);
        single("mflo", OP_MFLO, 32'h0000_0000, 32'h0000_0000, 5'd0, 32'h0000_0001);
        tick();
        iter("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        iter("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
        iter("multu 7*9 poke", OP_MULTU, 32'd7, 32'd9, 32'd0, 32'd63, 1'b1);
        single("ori", OP_ORI, 32'h1234_0000, 32'hABCD_5678, 5'd0, 32'h1234_5678);
        tick();
        chk("ori leaves hi", hi, 32'd0);
        chk("ori leaves lo", lo, 32'd63);

        // Reset in the middle of a DIVU.
        start  = 1'b1;
        Aluctl = OP_DIVU;
        input1 = 32'd1000;
        input2 = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", b2w(busy), b2w(1'b0));
        chk("abort done", b2w(done), b2w(1'b0));
        chk("abort hi", hi, '0);
        chk("abort lo", lo, '0);
        chk("abort Aluout", Aluout, '0);
        chk("abort zflag", b2w(zflag), b2w(1'b1));
        late_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) late_done++;
        end
        chk("abort no late done", W'(late_done), '0);

        iter("multu 3*4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
